// File: rtl/ym2149_psg_seq_wbm_pkg.sv
// Shared types for the YM2149 register-write sequencer: FSM states, queued
// command layout and the Wishbone drive bundle.
package psg_seq_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, REQ, ACK} state_t;

   typedef struct packed {
      logic [15:0] wait_ticks;
      logic [7:0]  adr;
      logic [7:0]  dat;
   } psg_cmd_t;

   localparam logic [3:0] PSG_WB_SEL = 4'b0001;

   typedef struct packed {
      logic        cyc;
      logic        stb;
      logic        we;
      logic [3:0]  sel;
      logic [7:0]  adr;
      logic [31:0] dat;
   } wb_drv_t;

   // Bus drive for the first cycle of a single register write.
   function automatic wb_drv_t wb_write(input psg_cmd_t c);
      wb_drv_t d;
      d.cyc = 1'b1;
      d.stb = 1'b1;
      d.we  = 1'b1;
      d.sel = PSG_WB_SEL;
      d.adr = c.adr;
      d.dat = {24'b0, c.dat};
      return d;
   endfunction

endpackage

// File: rtl/ym2149_psg_seq_wbm_fifo.sv
// Command FIFO for the PSG sequencer: single clock, first-word fall-through
// head, level output, and a one-cycle flush that also drops a same-cycle push.
module psg_cmd_fifo
   import psg_seq_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  psg_cmd_t                 push_data,
   input  logic                     pop,
   output psg_cmd_t                 head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   psg_cmd_t        r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_level;
   logic            w_push;
   logic            w_pop;

   assign full   = (r_level == (AW+1)'(DEPTH));
   assign empty  = (r_level == '0);
   assign level  = r_level;
   assign head   = r_mem[r_rd_ptr];
   assign w_push = push && !full && !flush;
   assign w_pop  = pop && !empty && !flush;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage needs no reset; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (w_push && !rst) r_mem[r_wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ym2149_psg_seq_wbm.sv
// Timed Wishbone write sequencer for the YM2149 PSG: queued commands are
// released as single pipelined writes after a per-command tick delay.
//
//   state | meaning
//   IDLE  | no write in flight; pops the FIFO head when one is present
//   WAIT  | counting down playback ticks for the popped command
//   REQ   | cyc/stb asserted, waiting for the slave to accept (stall low)
//   ACK   | accepted, stb dropped, waiting for ack/err
module ym2149_psg_seq_wbm
   import psg_seq_pkg::*;
#(
   parameter int CLK_IN_HZ   = 100000000,
   parameter int TICK_HZ     = 50,
   parameter int FIFO_DEPTH  = 16,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [15:0]                   cmd_wait,
   input  logic [7:0]                    cmd_adr,
   input  logic [7:0]                    cmd_dat,
   input  logic                          flush,
   output logic [7:0]                    wb_adr,
   output logic [31:0]                   wb_dat_w,
   input  logic [31:0]                   wb_dat_r,
   output logic [3:0]                    wb_sel,
   input  logic                          wb_stall,
   output logic                          wb_cyc,
   output logic                          wb_stb,
   output logic                          wb_we,
   input  logic                          wb_ack,
   input  logic                          wb_err,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          err_flag,
   input  logic                          err_clr
);

   localparam int TICK_DIV = CLK_IN_HZ / TICK_HZ;
   localparam int PW       = $clog2(TICK_DIV);
   localparam int TW       = $clog2(ACK_TIMEOUT + 1);

   logic [PW-1:0]  r_presc;
   state_t         r_state;
   psg_cmd_t       r_cur;
   logic [15:0]    r_remain;
   logic [TW-1:0]  r_to;
   wb_drv_t        r_wb;
   logic           r_err_flag;

   psg_cmd_t       w_cmd_in;
   psg_cmd_t       w_head;
   logic           w_full;
   logic           w_empty;
   logic           w_pop;
   logic           w_tick;
   logic           w_resp;
   logic           w_timeout;
   logic           w_err_set;
   logic           w_unused_dat_r;

   assign w_cmd_in       = '{wait_ticks: cmd_wait, adr: cmd_adr, dat: cmd_dat};
   assign w_pop          = (r_state == IDLE) && !w_empty && !flush;
   assign w_tick         = (r_presc == PW'(TICK_DIV - 1));
   assign w_resp         = wb_ack || wb_err;
   assign w_timeout      = r_wb.cyc && !w_resp && (r_to == '0);
   assign w_err_set      = (r_wb.cyc && wb_err) || w_timeout;
   assign w_unused_dat_r = ^wb_dat_r;

   assign cmd_ready = !w_full;
   assign busy      = (r_state != IDLE) || !w_empty;
   assign err_flag  = r_err_flag;
   assign wb_cyc    = r_wb.cyc;
   assign wb_stb    = r_wb.stb;
   assign wb_we     = r_wb.we;
   assign wb_sel    = r_wb.sel;
   assign wb_adr    = r_wb.adr;
   assign wb_dat_w  = r_wb.dat;

   psg_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (cmd_valid),
      .push_data (w_cmd_in),
      .pop       (w_pop),
      .head      (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .level     (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (rst || w_tick) r_presc <= '0;
      else               r_presc <= r_presc + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cur      <= '0;
         r_remain   <= '0;
         r_to       <= '0;
         r_wb       <= '0;
         r_err_flag <= 1'b0;
      end else begin
         if (w_err_set)    r_err_flag <= 1'b1;
         else if (err_clr) r_err_flag <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_cur    <= w_head;
                  r_remain <= w_head.wait_ticks;
                  if (w_head.wait_ticks == 16'd0) begin
                     r_state <= REQ;
                     r_wb    <= wb_write(w_head);
                     r_to    <= TW'(ACK_TIMEOUT - 1);
                  end else begin
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (flush) begin
                  r_state <= IDLE;
               end else if (w_tick) begin
                  r_remain <= r_remain - 16'd1;
                  if (r_remain == 16'd1) begin
                     r_state <= REQ;
                     r_wb    <= wb_write(r_cur);
                     r_to    <= TW'(ACK_TIMEOUT - 1);
                  end
               end
            end
            REQ, ACK: begin
               // A response wins over the timeout when both land on the last cycle.
               if (w_resp || w_timeout) begin
                  r_wb    <= '0;
                  r_state <= IDLE;
               end else begin
                  r_to <= r_to - TW'(1);
                  if (r_state == REQ && !wb_stall) begin
                     r_wb.stb <= 1'b0;
                     r_state  <= ACK;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ym2149_psg_seq_wbm.sv
// Scoreboard bench for ym2149_psg_seq_wbm: directed pushes queue expected
// writes; a bus monitor pops and checks each completed Wishbone cycle.
module tb_ym2149_psg_seq_wbm;

   localparam int TICK_DIV = 10;
   localparam int ACK_TO   = 24;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [15:0] cmd_wait = '0;
   logic [7:0]  cmd_adr = '0;
   logic [7:0]  cmd_dat = '0;
   logic        flush = 1'b0;
   logic [7:0]  wb_adr;
   logic [31:0] wb_dat_w;
   logic [31:0] wb_dat_r = 32'h0;
   logic [3:0]  wb_sel;
   logic        wb_stall = 1'b0;
   logic        wb_cyc, wb_stb, wb_we;
   logic        wb_ack = 1'b0;
   logic        wb_err = 1'b0;
   logic        busy;
   logic [4:0]  fifo_level;
   logic        err_flag;
   logic        err_clr = 1'b0;

   ym2149_psg_seq_wbm #(
      .CLK_IN_HZ(TICK_DIV * 50), .TICK_HZ(50), .FIFO_DEPTH(16), .ACK_TIMEOUT(ACK_TO)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_wait(cmd_wait), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .flush(flush),
      .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r), .wb_sel(wb_sel),
      .wb_stall(wb_stall), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
      .wb_ack(wb_ack), .wb_err(wb_err), .busy(busy), .fifo_level(fifo_level),
      .err_flag(err_flag), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] adr;
      logic [7:0] dat;
      int         len;    // 0: length not checked
      int         start;  // -1: start cycle not checked
   } exp_t;

   typedef enum int {SL_PSG, SL_HOLD, SL_NOACK} sl_mode_t;

   exp_t       sb[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc_n   = 0;
   int         rst_idx = 0;
   sl_mode_t   mode    = SL_PSG;
   logic [7:0] err_adr = 8'hFF;
   int         sc      = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Cycle index and the cycle of the last reset edge (prescaler origin).
   always @(posedge clk) begin
      cyc_n++;
      if (rst) rst_idx = cyc_n;
   end

   // Slave model: PSG mode stalls the first stb cycle, then acks (or errs).
   always @(negedge clk) begin
      wb_stall = 1'b0;
      wb_ack   = 1'b0;
      wb_err   = 1'b0;
      if (wb_cyc) begin
         case (mode)
            SL_HOLD:  wb_stall = 1'b1;
            SL_NOACK: wb_stall = 1'b0;
            default: begin
               if (wb_stb && sc == 0)    wb_stall = 1'b1;
               else if (wb_adr == err_adr) wb_err = 1'b1;
               else                       wb_ack = 1'b1;
            end
         endcase
         sc++;
      end else begin
         sc = 0;
      end
   end

   // Monitor: capture each bus cycle, compare against the scoreboard when cyc falls.
   logic        m_prev = 1'b0;
   logic [7:0]  m_adr;
   logic [31:0] m_dat;
   logic [3:0]  m_sel;
   logic        m_we, m_stb;
   int          m_len, m_start;

   always @(negedge clk) begin
      exp_t e;
      if (wb_cyc) begin
         if (!m_prev) begin
            m_adr = wb_adr; m_dat = wb_dat_w; m_sel = wb_sel;
            m_we = wb_we; m_stb = wb_stb; m_len = 1; m_start = cyc_n;
         end else begin
            m_len++;
         end
      end else if (m_prev) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got adr 0x%0h, expected no write", m_adr);
         end else begin
            e = sb.pop_front();
            check("wr_adr", m_adr, e.adr);
            check("wr_dat", m_dat, {24'b0, e.dat});
            check("wr_sel", m_sel, 4'b0001);
            check("wr_we_stb", {m_we, m_stb}, 2'b11);
            if (e.len > 0)    check("wr_cyc_len", m_len, e.len);
            if (e.start >= 0) check("wr_stb_cycle", m_start, e.start);
         end
      end
      m_prev = wb_cyc;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] w, input logic [7:0] a, input logic [7:0] d,
                       output int h);
      bit ok = 0;
      cmd_valid = 1'b1; cmd_wait = w; cmd_adr = a; cmd_dat = d;
      h = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1;
            h  = cyc_n;
            break;
         end
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL push_timeout: got no cmd_ready, expected accept of adr 0x%0h", a);
      end else begin
         step();
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check("busy_idle", busy, 0);
   endtask

   task automatic wait_cyc_fall(input int budget);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (wb_cyc) seen = 1;
         else if (seen) break;
      end
      check("cyc_fall", {seen, wb_cyc}, 2'b10);
   endtask

   // Cycle in which stb rises for a wait of n ticks popped in cycle p.
   function automatic int exp_start(input int p, input int n);
      int c = p;
      int k = 0;
      while (k < n) begin
         c++;
         if ((c - rst_idx) % TICK_DIV == TICK_DIV - 1) k++;
      end
      return c + 1;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int h, cnt;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cyc_stb_we", {wb_cyc, wb_stb, wb_we}, 3'b000);
      check("rst_sel", wb_sel, 0);
      check("rst_adr", wb_adr, 0);
      check("rst_dat", wb_dat_w, 0);
      check("rst_busy", busy, 0);
      check("rst_level", fifo_level, 0);
      check("rst_err_flag", err_flag, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      step();
      rst = 1'b0;

      // Single zero-wait write against the PSG slave.
      push(16'd0, 8'h07, 8'h38, h);
      sb.push_back('{adr: 8'h07, dat: 8'h38, len: 2, start: h + 2});
      wait_idle(50);

      // Three-tick delay, aligned to the prescaler.
      step();
      push(16'd3, 8'h08, 8'h0F, h);
      sb.push_back('{adr: 8'h08, dat: 8'h0F, len: 2, start: exp_start(h + 1, 3)});
      wait_idle(80);

      // Fill the FIFO behind a stalled write, then release.
      step();
      mode = SL_HOLD;
      for (int i = 0; i < 17; i++) begin
         push(16'd0, 8'(16 + i), 8'(160 + i), h);
         sb.push_back('{adr: 8'(16 + i), dat: 8'(160 + i),
                        len: (i == 0) ? 0 : 2, start: (i == 0) ? h + 2 : -1});
      end
      @(negedge clk);
      check("full_level", fifo_level, 16);
      check("full_cmd_ready", cmd_ready, 0);
      step();
      mode = SL_PSG;
      wait_idle(120);

      // Ack timeout, then the next command still goes out.
      step();
      mode = SL_NOACK;
      push(16'd0, 8'h20, 8'h11, h);
      sb.push_back('{adr: 8'h20, dat: 8'h11, len: ACK_TO, start: h + 2});
      push(16'd0, 8'h21, 8'h22, h);
      sb.push_back('{adr: 8'h21, dat: 8'h22, len: 2, start: -1});
      wait_cyc_fall(60);
      check("timeout_err_flag", err_flag, 1);
      step();
      mode = SL_PSG;
      wait_idle(40);
      check("err_flag_sticky", err_flag, 1);
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      @(negedge clk);
      check("err_clr", err_flag, 0);

      // Slave error with err_clr held: set wins, then clears; no retry.
      step();
      err_adr = 8'h30;
      err_clr = 1'b1;
      push(16'd0, 8'h30, 8'h55, h);
      sb.push_back('{adr: 8'h30, dat: 8'h55, len: 2, start: h + 2});
      push(16'd0, 8'h31, 8'h66, h);
      sb.push_back('{adr: 8'h31, dat: 8'h66, len: 2, start: -1});
      wait_cyc_fall(20);
      check("err_set_wins", err_flag, 1);
      @(negedge clk);
      check("err_clr_after", err_flag, 0);
      step();
      err_clr = 1'b0;
      wait_idle(30);
      err_adr = 8'hFF;

      // Flush during WAIT with five queued; a push in the flush cycle is dropped.
      step();
      push(16'd2, 8'h40, 8'h00, h);
      for (int i = 1; i <= 5; i++) push(16'd0, 8'(64 + i), 8'(i), h);
      flush = 1'b1;
      cmd_valid = 1'b1; cmd_wait = 16'd0; cmd_adr = 8'h46; cmd_dat = 8'h06;
      step();
      flush = 1'b0;
      cmd_valid = 1'b0;
      @(negedge clk);
      check("flush_level", fifo_level, 0);
      check("flush_busy", busy, 0);
      check("flush_cmd_ready", cmd_ready, 1);
      cnt = 0;
      repeat (50) begin
         @(negedge clk);
         if (wb_cyc) cnt++;
      end
      check("flush_no_write", cnt, 0);

      // Reset while a write is held in REQ.
      step();
      mode = SL_HOLD;
      push(16'd0, 8'h50, 8'h77, h);
      sb.push_back('{adr: 8'h50, dat: 8'h77, len: 1, start: h + 2});
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (wb_cyc) break;
      end
      check("req_before_rst", wb_cyc, 1);
      rst = 1'b1;
      step();
      check("rst_mid_req_bus", {wb_cyc, wb_stb, wb_we, wb_sel}, 0);
      check("rst_mid_req_adr", wb_adr, 0);
      check("rst_mid_req_busy", busy, 0);
      rst = 1'b0;
      mode = SL_PSG;

      // Normal operation after the reset.
      step();
      push(16'd0, 8'h60, 8'h01, h);
      sb.push_back('{adr: 8'h60, dat: 8'h01, len: 2, start: h + 2});
      wait_idle(30);
      repeat (3) @(negedge clk);
      check("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
